// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side
// instruction handshake.
interface if_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem read, single-entry buffer to decode.
// Optional IF_FETCH_PERF_EN adds fetch/stall performance counters.
module if_fetch #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    output logic [1:0]    pc_mode,
    input  logic          redir_valid,
    input  logic          redir_src,
    if_fetch_if.master    bus,
    output logic [2:0]    dbg_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4
    } state_t;

    localparam logic [1:0] PC_STALL     = 2'b00;
    localparam logic [1:0] PC_NORMAL    = 2'b01;
    localparam logic [1:0] PC_REGISTER  = 2'b10;
    localparam logic [1:0] PC_IMMEDIATE = 2'b11;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          inst_valid_q;
    logic [DW-1:0] inst_q;
    logic [AW-1:0] inst_pc_q;

    // Decode handshake: an instruction transfers on any cycle where inst_valid
    // and inst_ready are both high; inst/inst_pc stay stable while inst_valid
    // is high and not accepted, and inst_valid never drops without a transfer
    // except on a redirect flush.
    assign bus.imem_req   = (state == ISSUE);
    assign bus.imem_addr  = (state == ISSUE) ? pc : '0;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign dbg_state      = state;

    // pc_mode reacts to redirect/rvalid in the same cycle so the PC register
    // updates on the edge that ends that cycle.
    always_comb begin
        pc_mode = PC_STALL;
        if (redir_valid)
            pc_mode = redir_src ? PC_IMMEDIATE : PC_REGISTER;
        else if (state == WAIT && bus.imem_rvalid)
            pc_mode = PC_NORMAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else if (redir_valid) begin
            inst_valid_q <= 1'b0;
            case (state)
                ISSUE:      state <= DROP;
                WAIT, DROP: state <= bus.imem_rvalid ? ISSUE : DROP;
                default:    state <= ISSUE;
            endcase
        end else begin
            case (state)
                IDLE:  state <= ISSUE;
                ISSUE: begin
                    addr_q <= pc;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        inst_q       <= bus.imem_rdata;
                        inst_pc_q    <= addr_q;
                        inst_valid_q <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_valid_q && bus.inst_ready) begin
                        inst_valid_q <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid)
                        state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    // Stall counts every cycle spent waiting on memory or on decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state == WAIT && bus.imem_rvalid && !redir_valid)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == WAIT || state == DROP || (state == HOLD && !bus.inst_ready))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: scripted imem responses, decode handshake,
// redirects and async reset, with a scoreboard of expected instructions.
module tb_if_fetch;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_HOLD = 3'd3, S_DROP = 3'd4;

  logic clk, rst_n;
  logic [AW-1:0] pc;
  logic [1:0] pc_mode;
  logic redir_valid, redir_src;
  logic [2:0] dbg_state;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_fetch_if #(.DW(DW), .AW(AW)) bus ();

  if_fetch #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_mode(pc_mode),
    .redir_valid(redir_valid), .redir_src(redir_src), .bus(bus), .dbg_state(dbg_state)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic issue_step();
    @(negedge clk);
    bus.imem_rvalid = 1'b0; redir_valid = 1'b0; bus.inst_ready = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL issue_req got %0b exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== pc) begin errors++; $display("FAIL issue_addr got %h exp %h", bus.imem_addr, pc); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL issue_inst_valid got %0b exp 0", bus.inst_valid); end
    checks++; if (pc_mode !== 2'b00) begin errors++; $display("FAIL issue_pc_mode got %b exp 00", pc_mode); end
  endtask

  task automatic wait_capture(input logic [DW-1:0] d, input int lat);
    for (int i = 0; i < lat - 1; i++) begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      #1;
      checks++; if (pc_mode !== 2'b00) begin errors++; $display("FAIL wait_pc_mode got %b exp 00", pc_mode); end
      checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== '0) begin errors++; $display("FAIL wait_req got %0b/%h exp 0/0", bus.imem_req, bus.imem_addr); end
      checks++; if (dbg_state !== S_WAIT) begin errors++; $display("FAIL wait_state got %0d exp %0d", dbg_state, S_WAIT); end
    end
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = d;
    exp_q.push_back(d); exp_pc_q.push_back(pc);
    #1;
    checks++; if (pc_mode !== 2'b01) begin errors++; $display("FAIL capture_pc_mode got %b exp 01", pc_mode); end
    pc = pc + 1;
  endtask

  task automatic hold_accept(input int hold_wait);
    logic [DW-1:0] e;
    logic [AW-1:0] ep;
    for (int i = 0; i < hold_wait; i++) begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0;
      #1;
      checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %0b exp 1", bus.inst_valid); end
      checks++; if (pc_mode !== 2'b00) begin errors++; $display("FAIL hold_pc_mode got %b exp 00", pc_mode); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %0b exp 0", bus.imem_req); end
    end
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL accept_valid got %0b exp 1", bus.inst_valid); end
    checks++; if (pc_mode !== 2'b00) begin errors++; $display("FAIL accept_pc_mode got %b exp 00", pc_mode); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL sb_empty got inst %h exp none queued", bus.inst);
    end else begin
      e = exp_q.pop_front(); ep = exp_pc_q.pop_front();
      if (bus.inst !== e || bus.inst_pc !== ep) begin
        errors++; $display("FAIL sb_inst got %h@%h exp %h@%h", bus.inst, bus.inst_pc, e, ep);
      end
    end
  endtask

  task automatic fetch_one(input logic [DW-1:0] d, input int lat, input int hold_wait);
    issue_step();
    wait_capture(d, lat);
    hold_accept(hold_wait);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; pc = 32'h10; redir_valid = 1'b0; redir_src = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pc_mode !== 2'b00 || bus.imem_req !== 1'b0 || bus.imem_addr !== '0) begin
      errors++; $display("FAIL reset_ctl got %b/%0b/%h exp 00/0/0", pc_mode, bus.imem_req, bus.imem_addr); end
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== '0 || bus.inst_pc !== '0) begin
      errors++; $display("FAIL reset_inst got %0b/%h/%h exp 0/0/0", bus.inst_valid, bus.inst, bus.inst_pc); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b exp 0", bus.imem_req); end
  endtask

  task automatic test_basic();
    issue_step();
    checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL basic_addr got %h exp 00000010", bus.imem_addr); end
    wait_capture(32'hA5A5_0001, 2);
    hold_accept(0);
    fetch_one(32'h1234_5678, 1, 0);
    fetch_one($urandom, $urandom_range(1, 4), $urandom_range(0, 2));
  endtask

  task automatic test_hold_stall();
    fetch_one(32'hCAFE_0002, 1, 5);
  endtask

  task automatic test_redirect_wait();
    issue_step();
    @(negedge clk);
    redir_valid = 1'b1; redir_src = 1'b1;
    #1;
    checks++; if (pc_mode !== 2'b11) begin errors++; $display("FAIL redir_wait_pc_mode got %b exp 11", pc_mode); end
    pc = 32'h200;
    @(negedge clk);
    redir_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== S_DROP) begin errors++; $display("FAIL drop_state got %0d exp %0d", dbg_state, S_DROP); end
    checks++; if (pc_mode !== 2'b00 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL drop_out got %b/%0b exp 00/0", pc_mode, bus.inst_valid); end
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (pc_mode !== 2'b00) begin errors++; $display("FAIL drop_rvalid_pc_mode got %b exp 00", pc_mode); end
    fetch_one(32'h0000_0200, 2, 1);
  endtask

  task automatic test_redirect_hold();
    issue_step();
    wait_capture(32'hBAD0_0003, 1);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0; redir_valid = 1'b1; redir_src = 1'b0;
    #1;
    checks++; if (pc_mode !== 2'b10) begin errors++; $display("FAIL redir_hold_pc_mode got %b exp 10", pc_mode); end
    checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL redir_hold_valid got %0b exp 1", bus.inst_valid); end
    void'(exp_q.pop_back()); void'(exp_pc_q.pop_back());
    pc = 32'h300;
    fetch_one(32'h0000_0300, 1, 0);
    // redirect while decode accepts: the instruction is delivered anyway
    issue_step();
    wait_capture(32'h0000_0301, 1);
    hold_accept(0);
    redir_valid = 1'b1; redir_src = 1'b1;
    #1;
    checks++; if (pc_mode !== 2'b11) begin errors++; $display("FAIL redir_accept_pc_mode got %b exp 11", pc_mode); end
    pc = 32'h380;
    fetch_one(32'h0000_0380, 1, 0);
  endtask

  task automatic test_redirect_rvalid();
    issue_step();
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0004; redir_valid = 1'b1; redir_src = 1'b1;
    #1;
    checks++; if (pc_mode !== 2'b11) begin errors++; $display("FAIL redir_rvalid_pc_mode got %b exp 11", pc_mode); end
    pc = 32'h400;
    fetch_one(32'h0000_0400, 1, 0);
  endtask

  task automatic test_back_to_back_redirect();
    issue_step();
    @(negedge clk);
    redir_valid = 1'b1; redir_src = 1'b0;
    #1;
    checks++; if (pc_mode !== 2'b10) begin errors++; $display("FAIL b2b_first got %b exp 10", pc_mode); end
    @(negedge clk);
    redir_valid = 1'b1; redir_src = 1'b1;
    #1;
    checks++; if (pc_mode !== 2'b11) begin errors++; $display("FAIL b2b_second got %b exp 11", pc_mode); end
    pc = 32'h500;
    @(negedge clk);
    redir_valid = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0005;
    #1;
    checks++; if (pc_mode !== 2'b00 || dbg_state !== S_DROP) begin errors++; $display("FAIL b2b_drop got %b/%0d exp 00/%0d", pc_mode, dbg_state, S_DROP); end
    fetch_one(32'h0000_0500, 3, 0);
  endtask

  task automatic test_async_reset();
    issue_step();
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_mode !== 2'b00 || bus.imem_req !== 1'b0 || bus.imem_addr !== '0) begin
      errors++; $display("FAIL arst_ctl got %b/%0b/%h exp 00/0/0", pc_mode, bus.imem_req, bus.imem_addr); end
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== '0 || bus.inst_pc !== '0) begin
      errors++; $display("FAIL arst_inst got %0b/%h/%h exp 0/0/0", bus.inst_valid, bus.inst, bus.inst_pc); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL arst_state got %0d exp 0", dbg_state); end
`ifdef IF_FETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL arst_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    @(negedge clk);
    pc = 32'h20;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) fetch_one(32'h7000_0000 + i, 2, 1);
    @(negedge clk);
    #1;
`ifdef IF_FETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd3) begin errors++; $display("FAIL perf_fetch got %0d exp 3", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 32'd9) begin errors++; $display("FAIL perf_stall got %0d exp 9", perf_stall_cnt); end
`endif
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h23) begin
      errors++; $display("FAIL post_reset_issue got %0b/%h exp 1/00000023", bus.imem_req, bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_rvalid();
    test_back_to_back_redirect();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
